// File: rtl/fpu_loader_pkg.sv
// rtl/fpu_loader_pkg.sv - shared types and widths for the FPU operand loader
// Contents: byte tag enum, loader state enum, word/byte widths.
package fpu_loader_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        TAG_IDLE = 2'b00,
        TAG_A    = 2'b01,
        TAG_B    = 2'b10,
        TAG_CMD  = 2'b11
    } tag_t;

    typedef enum logic {
        COLLECT = 1'b0,
        ISSUE   = 1'b1
    } state_t;

endpackage

// File: rtl/fpu_operand_loader_if.sv
// rtl/fpu_operand_loader_if.sv - byte input and command handshake bundle of the FPU loader
// Signals:
//   in_tag   byte tag (idle / A byte / B byte / command)
//   in_val   byte payload
//   op_valid command pending to core
//   op_ready core accepts command this cycle
//   op_code  opcode of the pending command
//   a_out    operand A
//   b_out    operand B
//   busy     command pending, input bytes ignored
//   err      sticky protocol error flag
// Modports: slave = loader side, master = pin/core side.
interface fpu_operand_loader_if #(
    parameter int OP_W = 4
);
    import fpu_loader_pkg::*;

    logic [1:0]        in_tag;
    logic [BYTE_W-1:0] in_val;
    logic              op_valid;
    logic              op_ready;
    logic [OP_W-1:0]   op_code;
    logic [WORD_W-1:0] a_out;
    logic [WORD_W-1:0] b_out;
    logic              busy;
    logic              err;

    modport slave (
        input  in_tag, in_val, op_ready,
        output op_valid, op_code, a_out, b_out, busy, err
    );

    modport master (
        output in_tag, in_val, op_ready,
        input  op_valid, op_code, a_out, b_out, busy, err
    );

endinterface

// File: rtl/byte_pair_reg.sv
// rtl/byte_pair_reg.sv - 16-bit operand register loaded high byte first through a toggling byte pointer
// Ports:
//   clock    system clock
//   reset    synchronous active-high reset (clears value and pointer)
//   wr_en    write din at the current pointer, then toggle the pointer
//   ptr_clr  return the pointer to the high byte (wins over wr_en)
//   din      byte to write
//   q        assembled 16-bit value
//   ptr_low  pointer currently addresses the low byte
module byte_pair_reg
    import fpu_loader_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              ptr_clr,
    input  logic [BYTE_W-1:0] din,
    output logic [WORD_W-1:0] q,
    output logic              ptr_low
);

    always_ff @(posedge clock) begin
        if (reset) begin
            q       <= '0;
            ptr_low <= 1'b0;
        end else if (ptr_clr) begin
            ptr_low <= 1'b0;
        end else if (wr_en) begin
            if (ptr_low) begin
                q[BYTE_W-1:0] <= din;
            end else begin
                q[WORD_W-1:BYTE_W] <= din;
            end
            // A third byte wraps back onto the high byte.
            ptr_low <= ~ptr_low;
        end
    end

endmodule

// File: rtl/fpu_operand_loader.sv
// rtl/fpu_operand_loader.sv - deserializes tagged bytes into two FP16 operands and issues commands to the FPU core
// Optional feature: define FPU_LOADER_ERR_EN to enable sticky protocol error detection on err.
// Ports:
//   clock  system clock
//   reset  synchronous active-high reset
//   bus    fpu_operand_loader_if.slave (tagged byte input, command handshake, operands, busy, err)
module fpu_operand_loader
    import fpu_loader_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    fpu_operand_loader_if.slave  bus
);

    state_t          state;
    tag_t            tag;
    logic [OP_W-1:0] op_code_q;
    logic            op_valid_q;
    logic            busy_q;
    logic            wr_a;
    logic            wr_b;
    logic            handshake;
    logic            a_ptr_low;
    logic            b_ptr_low;

    assign tag = tag_t'(bus.in_tag);

    // Bytes only land while collecting; anything arriving during ISSUE is dropped.
    assign wr_a      = (state == COLLECT) && (tag == TAG_A);
    assign wr_b      = (state == COLLECT) && (tag == TAG_B);
    assign handshake = (state == ISSUE) && bus.op_ready;

    byte_pair_reg u_reg_a (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_a),
        .ptr_clr (handshake),
        .din     (bus.in_val),
        .q       (bus.a_out),
        .ptr_low (a_ptr_low)
    );

    byte_pair_reg u_reg_b (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_b),
        .ptr_clr (handshake),
        .din     (bus.in_val),
        .q       (bus.b_out),
        .ptr_low (b_ptr_low)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= COLLECT;
            op_code_q  <= '0;
            op_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (tag == TAG_CMD) begin
                        state      <= ISSUE;
                        op_code_q  <= bus.in_val[OP_W-1:0];
                        op_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (bus.op_ready) begin
                        state      <= COLLECT;
                        op_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    state      <= COLLECT;
                    op_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.op_code  = op_code_q;
    assign bus.op_valid = op_valid_q;
    assign bus.busy     = busy_q;

`ifdef FPU_LOADER_ERR_EN
    logic err_q;

    // Odd byte count at command time, or traffic while a command is pending.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if ((state == COLLECT) && (tag == TAG_CMD) && (a_ptr_low || b_ptr_low)) begin
            err_q <= 1'b1;
        end else if ((state == ISSUE) && (tag != TAG_IDLE)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    logic unused_ptr;
    assign unused_ptr = a_ptr_low ^ b_ptr_low;
    assign bus.err    = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_operand_loader.sv
// tb/tb_fpu_operand_loader.sv - directed self-checking bench for fpu_operand_loader
module tb_fpu_operand_loader;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_mis;

`ifdef FPU_LOADER_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    fpu_operand_loader_if #(.OP_W(4)) bus ();

    fpu_operand_loader #(.OP_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step(input logic [1:0] t, input logic [7:0] v);
        bus.in_tag = t;
        bus.in_val = v;
        @(posedge clock);
        #1;
        bus.in_tag = 2'b00;
        bus.in_val = 8'h00;
    endtask

    task automatic load_4e54();
        step(2'b01, 8'h4E);
        step(2'b01, 8'h54);
        step(2'b10, 8'h4E);
        step(2'b10, 8'h54);
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        reset = 1'b1;
        bus.in_tag   = 2'b00;
        bus.in_val   = 8'h00;
        bus.op_ready = 1'b0;
        step(2'b00, 8'h00);
        step(2'b00, 8'h00);
        reset = 1'b0;

        check("rst_op_valid", bus.op_valid, 0);
        check("rst_busy",     bus.busy, 0);
        check("rst_op_code",  bus.op_code, 0);
        check("rst_a_out",    bus.a_out, 0);
        check("rst_b_out",    bus.b_out, 0);
        check("rst_err",      bus.err, 0);

        // Basic load and issue with the core already ready.
        step(2'b01, 8'h4E);
        check("a_high_byte", bus.a_out, 16'h4E00);
        step(2'b01, 8'h54);
        step(2'b10, 8'h4E);
        step(2'b10, 8'h54);
        check("t1_a_out", bus.a_out, 16'h4E54);
        check("t1_b_out", bus.b_out, 16'h4E54);
        bus.op_ready = 1'b1;
        step(2'b11, 8'h02);
        check("t1_op_valid", bus.op_valid, 1);
        check("t1_busy",     bus.busy, 1);
        check("t1_op_code",  bus.op_code, 4'h2);
        step(2'b00, 8'h00);
        check("t1_one_cycle", bus.op_valid, 0);
        check("t1_busy_low",  bus.busy, 0);

        // Reissue with no new bytes reuses the operands.
        step(2'b11, 8'h01);
        check("t3_op_valid", bus.op_valid, 1);
        check("t3_op_code",  bus.op_code, 4'h1);
        check("t3_a_out",    bus.a_out, 16'h4E54);
        check("t3_b_out",    bus.b_out, 16'h4E54);
        check("t3_err",      bus.err, 0);
        step(2'b00, 8'h00);
        check("t3_done", bus.op_valid, 0);

        // Three A bytes: pointer wraps onto the high byte.
        step(2'b01, 8'h11);
        check("odd_a1", bus.a_out, 16'h1154);
        step(2'b01, 8'h22);
        check("odd_a2", bus.a_out, 16'h1122);
        step(2'b01, 8'h33);
        check("odd_a3", bus.a_out, 16'h3322);
        check("odd_b",  bus.b_out, 16'h4E54);
        step(2'b11, 8'h05);
        check("odd_op_valid", bus.op_valid, 1);
        check("odd_op_code",  bus.op_code, 4'h5);
        check("odd_err",      bus.err, EXP_ERR);
        step(2'b00, 8'h00);
        check("odd_done",       bus.op_valid, 0);
        check("odd_err_sticky", bus.err, EXP_ERR);

        // Reset while a command is pending.
        bus.op_ready = 1'b0;
        step(2'b11, 8'h07);
        check("rm_op_valid", bus.op_valid, 1);
        reset = 1'b1;
        step(2'b00, 8'h00);
        reset = 1'b0;
        check("rm_op_valid0", bus.op_valid, 0);
        check("rm_busy",      bus.busy, 0);
        check("rm_op_code",   bus.op_code, 0);
        check("rm_a_out",     bus.a_out, 0);
        check("rm_b_out",     bus.b_out, 0);
        check("rm_err",       bus.err, 0);

        // Fresh load, core stalls 3 cycles while A bytes are thrown at it.
        load_4e54();
        check("st_a_out", bus.a_out, 16'h4E54);
        check("st_b_out", bus.b_out, 16'h4E54);
        step(2'b11, 8'hF3);
        check("st_op_code", bus.op_code, 4'h3);
        for (int i = 0; i < 3; i++) begin
            check("st_hold_valid", bus.op_valid, 1);
            step(2'b01, 8'hFF);
            check("st_busy",    bus.busy, 1);
            check("st_a_keep",  bus.a_out, 16'h4E54);
            check("st_code_keep", bus.op_code, 4'h3);
        end
        check("st_valid_4th", bus.op_valid, 1);
        bus.op_ready = 1'b1;
        step(2'b01, 8'hFF);
        check("st_hs_valid", bus.op_valid, 0);
        check("st_hs_busy",  bus.busy, 0);
        check("st_hs_drop",  bus.a_out, 16'h4E54);
        check("st_err",      bus.err, EXP_ERR);
        bus.op_ready = 1'b0;
        step(2'b01, 8'h12);
        check("st_next_high", bus.a_out, 16'h1254);
        step(2'b01, 8'h34);
        check("st_next_low",  bus.a_out, 16'h1234);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
